// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the segmented pipelined adder: stage count helper,
// configuration check and the bit layout of one stage's state record.
package pipe_adder_pkg;

    // Stage record, LSB first: valid, carry out, carry into segment MSB,
    // then the partial sum, the effective B operand and the A operand.
    localparam int REC_VALID = 0;
    localparam int REC_CARRY = 1;
    localparam int REC_CMSB  = 2;
    localparam int REC_S_LSB = 3;

    function automatic int nseg(input int width, input int seg);
        return (seg > 0) ? width / seg : 0;
    endfunction

    function automatic bit seg_fit(input int width, input int seg);
        return (seg > 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

    function automatic int rec_bb_lsb(input int width);
        return REC_S_LSB + width;
    endfunction

    function automatic int rec_a_lsb(input int width);
        return REC_S_LSB + 2 * width;
    endfunction

    function automatic int rec_width(input int width);
        return REC_S_LSB + 3 * width;
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One pipeline stage: adds segment IDX of the operands with the incoming
// carry and holds the result in an elastic register with valid/ready.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_bb,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_bb,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             out_cmsb
);

    localparam int RW  = rec_width(WIDTH);
    localparam int LO  = IDX * SEG;
    localparam int MSB = LO + SEG - 1;
    localparam int BBL = rec_bb_lsb(WIDTH);
    localparam int AL  = rec_a_lsb(WIDTH);

    logic [RW-1:0]    state_q;
    logic [RW-1:0]    state_d;
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] s_next;
    logic             cmsb_next;
    logic             load;

    assign in_ready = !state_q[REC_VALID] || out_ready;
    assign load     = in_valid && in_ready;

    always_comb begin
        seg_sum = {1'b0, in_a[LO +: SEG]} + {1'b0, in_bb[LO +: SEG]}
                + {{SEG{1'b0}}, in_c};
        s_next            = in_s;
        s_next[LO +: SEG] = seg_sum[SEG-1:0];
        // Carry into the MSB recovered from the sum bit and both operand bits.
        cmsb_next = seg_sum[SEG-1] ^ in_a[MSB] ^ in_bb[MSB];
        state_d   = state_q;
        if (load) begin
            state_d = {in_a, in_bb, s_next, cmsb_next, seg_sum[SEG], 1'b1};
        end else if (out_ready) begin
            state_d[REC_VALID] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign out_valid = state_q[REC_VALID];
    assign out_c     = state_q[REC_CARRY];
    assign out_cmsb  = state_q[REC_CMSB];
    assign out_s     = state_q[REC_S_LSB +: WIDTH];
    assign out_bb    = state_q[BBL +: WIDTH];
    assign out_a     = state_q[AL +: WIDTH];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor built from WIDTH/SEG carry-chained
// segment stages, with valid/ready handshaking and full backpressure.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             os
);

    localparam int NSEG = nseg(WIDTH, SEG);

    if (!seg_fit(WIDTH, SEG)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a positive multiple of SEG");
    end

    logic [WIDTH-1:0] bb;
    logic             c0;
    logic [NSEG:0]    v_chain;
    logic [NSEG:0]    r_chain;
    logic [NSEG:0]    c_chain;
    logic [NSEG:0]    cmsb_chain;
    logic [WIDTH-1:0] a_chain  [NSEG+1];
    logic [WIDTH-1:0] bb_chain [NSEG+1];
    logic [WIDTH-1:0] s_chain  [NSEG+1];
    logic             unused_tail;

    // Subtraction is a + ~b + 1; a borrow-in cancels the +1.
    assign bb = sub ? ~b : b;
    assign c0 = sub ^ ci;

    assign v_chain[0]    = in_valid;
    assign in_ready      = r_chain[0];
    assign a_chain[0]    = a;
    assign bb_chain[0]   = bb;
    assign s_chain[0]    = '0;
    assign c_chain[0]    = c0;
    assign cmsb_chain[0] = 1'b0;
    assign r_chain[NSEG] = out_ready;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        pipe_adder_stage #(
            .WIDTH(WIDTH),
            .SEG  (SEG),
            .IDX  (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .in_valid (v_chain[k]),
            .in_ready (r_chain[k]),
            .in_a     (a_chain[k]),
            .in_bb    (bb_chain[k]),
            .in_s     (s_chain[k]),
            .in_c     (c_chain[k]),
            .out_valid(v_chain[k+1]),
            .out_ready(r_chain[k+1]),
            .out_a    (a_chain[k+1]),
            .out_bb   (bb_chain[k+1]),
            .out_s    (s_chain[k+1]),
            .out_c    (c_chain[k+1]),
            .out_cmsb (cmsb_chain[k+1])
        );
    end

    assign out_valid = v_chain[NSEG];
    assign s         = s_chain[NSEG];
    assign co        = c_chain[NSEG];
    assign os        = cmsb_chain[NSEG] ^ c_chain[NSEG];

    assign unused_tail = ^{a_chain[NSEG], bb_chain[NSEG], cmsb_chain[NSEG-1:0]};

endmodule

// File: tb/tb_pipe_adder.sv
// Randomised and directed bench for pipe_adder (WIDTH=16, SEG=8) checked
// against an arithmetic reference model and an in-order result queue.
module tb_pipe_adder;

    localparam int NSEG = 2;

    typedef struct {
        logic [17:0] res;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        co;
    logic        os;

    exp_t        q[$];
    int          checks;
    int          errors;
    int          cycle;
    bit          armed;
    logic        smp_ov;
    logic        smp_ir;
    logic        smp_acc;
    logic        smp_emit;
    logic [17:0] smp_res;
    logic [17:0] last_res;

    pipe_adder #(.WIDTH(16), .SEG(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .ci       (ci),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .co       (co),
        .os       (os)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    // Result as {os, co, s} from plain signed/unsigned integer arithmetic.
    function automatic logic [17:0] refCalc(input logic [15:0] ia, input logic [15:0] ib,
                                            input logic ici, input logic isub);
        logic [15:0] bbv;
        longint      c0;
        longint      usum;
        longint      ssum;
        logic [15:0] sum16;
        bbv   = isub ? ~ib : ib;
        c0    = (isub ^ ici) ? 64'sd1 : 64'sd0;
        usum  = longint'(ia) + longint'(bbv) + c0;
        ssum  = longint'($signed(ia)) + longint'($signed(bbv)) + c0;
        sum16 = usum[15:0];
        return {(ssum > 32767) || (ssum < -32768), usum > 65535, sum16};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cycle);
        end
    endtask

    // Drive one cycle of inputs, sample at the falling edge, update the model.
    task automatic applyStimulus(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                                 input logic ici, input logic isub, input logic iordy,
                                 input logic irst);
        exp_t e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        ci        = ici;
        sub       = isub;
        out_ready = iordy;
        rst       = irst;
        @(negedge clk);
        cycle++;
        smp_ov   = out_valid;
        smp_ir   = in_ready;
        smp_res  = {os, co, s};
        smp_acc  = iv && in_ready && !irst;
        smp_emit = out_valid && iordy && !irst;
        if (armed && out_valid) begin
            checkOutput("beat_pending", 64'(q.size() != 0), 1);
            if (q.size() != 0) begin
                checkOutput("result", 64'(smp_res), 64'(q[0].res));
                checkOutput("not_early", 64'(cycle - q[0].acc >= NSEG), 1);
            end
        end
        if (irst) begin
            q.delete();
            armed = 1'b1;
        end else begin
            if (smp_emit && q.size() != 0) begin
                last_res = smp_res;
                void'(q.pop_front());
            end
            if (smp_acc) begin
                e.res = refCalc(ia, ib, ici, isub);
                e.acc = cycle;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic iordy);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, iordy, 1'b0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        checkOutput({tag, "_empty"}, 64'(q.size()), 0);
        checkOutput({tag, "_ov"}, 64'(smp_ov), 0);
    endtask

    task automatic runDirected(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                               input logic ici, input logic isub, input logic [17:0] expv);
        int n;
        applyStimulus(1'b1, ia, ib, ici, isub, 1'b1, 1'b0);
        checkOutput({tag, "_accept"}, 64'(smp_acc), 1);
        n = 0;
        smp_emit = 1'b0;
        while (!smp_emit && n < 10) begin
            idle(1'b1);
            n++;
        end
        checkOutput({tag, "_emitted"}, 64'(smp_emit), 1);
        checkOutput(tag, 64'(smp_res), 64'(expv));
    endtask

    logic [15:0] bpa [6];
    logic [15:0] bpb [6];

    initial begin
        int idx;
        int n;
        checks   = 0;
        errors   = 0;
        cycle    = 0;
        armed    = 1'b0;
        last_res = '0;

        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h1234, 16'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_ov", 64'(smp_ov), 0);
        checkOutput("rst_res", 64'(smp_res), 0);
        idle(1'b1);
        checkOutput("post_rst_ready", 64'(smp_ir), 1);
        checkOutput("post_rst_ov", 64'(smp_ov), 0);
        checkOutput("post_rst_res", 64'(smp_res), 0);

        applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("lat_accept", 64'(smp_acc), 1);
        idle(1'b1);
        checkOutput("lat_c1_ov", 64'(smp_ov), 0);
        idle(1'b1);
        checkOutput("lat_c2_ov", 64'(smp_ov), 1);
        checkOutput("add_ovf", 64'(smp_res), 64'({1'b1, 1'b0, 16'h8000}));
        drain("d0");

        runDirected("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        runDirected("sub_neg",  16'h0000, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFF});
        runDirected("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        runDirected("sub_bin",  16'h0005, 16'h0003, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0001});
        drain("d1");

        for (int i = 0; i < 6; i++) begin
            bpa[i] = 16'($urandom);
            bpb[i] = 16'($urandom);
        end
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, bpa[idx], bpb[idx], 1'b0, 1'(idx % 2), 1'b0, 1'b0);
            if (smp_acc) idx++;
        end
        checkOutput("bp_accepts", 64'(idx), 2);
        checkOutput("bp_ready_low", 64'(smp_ir), 0);
        checkOutput("bp_ov_held", 64'(smp_ov), 1);
        n = 0;
        while (idx < 6 && n < 40) begin
            applyStimulus(1'b1, bpa[idx], bpb[idx], 1'b0, 1'(idx % 2), 1'b1, 1'b0);
            if (smp_acc) idx++;
            n++;
        end
        checkOutput("bp_all_fed", 64'(idx), 6);
        drain("d2");

        applyStimulus(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        drain("d3");
        checkOutput("seg_carry", 64'(last_res), 64'({1'b0, 1'b0, 16'h0100}));

        applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        checkOutput("mid_rst_ov", 64'(smp_ov), 0);
        checkOutput("mid_rst_ready", 64'(smp_ir), 1);
        idle(1'b1);
        idle(1'b1);
        checkOutput("mid_rst_quiet", 64'(smp_ov), 0);
        runDirected("after_rst", 16'h1234, 16'h0F0F, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2143});
        drain("d4");

        for (int i = 0; i < 600; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            case ($urandom_range(0, 5))
                0:       ra = 16'h7FFF;
                1:       ra = 16'h8000;
                2:       ra = 16'hFFFF;
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 16'h0001;
                1:       rb = 16'h8000;
                2:       rb = 16'h0000;
                default: rb = 16'($urandom);
            endcase
            applyStimulus(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0);
        end
        drain("d5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined two's-complement adder/subtractor for the multiplier datapath. It generalises the fixed 16-bit, two-segment ripple adder into a WIDTH-bit adder split into WIDTH/SEG segments, with one register stage per segment. It adds a subtract mode, a carry/borrow input and a valid/ready handshake with full backpressure. It serves as the final carry-propagate adder after the Dadda/CSA reduction tree, or as a standalone wide add unit.

## Interface
- WIDTH, default 16: operand and result width. Must be a multiple of SEG.
- SEG, default 8: segment width. NSEG = WIDTH/SEG pipeline stages; NSEG ≥ 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in (add) or borrow-in (subtract).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  sum or difference.
- co  output  1  carry out of the MSB (for subtract: 1 = no borrow).
- os  output  1  signed overflow.

## Operation
- Arithmetic:
  - Effective operand bb = sub ? ~b : b.
  - Effective carry-in c0 = sub ^ ci.
  - {co, s} = a + bb + c0, computed in WIDTH+1 bits.
  - Consequences: sub=1, ci=0 gives a−b; sub=1, ci=1 gives a−b−1.
- os = carry into the MSB XOR co. This equals a[MSB]==bb[MSB] && s[MSB]!=a[MSB].
- Stage k (k = 0..NSEG−1):
  - Adds segment k of a and bb with the carry held from stage k−1; stage 0 uses c0.
  - Registers the segment sum, the carry out, and the carry into the segment MSB.
  - Forwards the not-yet-used upper operand segments and all lower sum segments.
- Last stage: presents s as the concatenation of all segment sums. co and os come from the final segment.
- Each stage holds a valid bit. A stage loads when its own register is empty or its contents advance in the same cycle.
- A transfer occurs when in_valid && in_ready (input side) or out_valid && out_ready (output side).
- Beats are never dropped, duplicated or reordered.
- In-flight beats are independent. The sub and ci values of one beat never affect another beat.

## Timing
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NSEG−1. This is the first cycle it is visible, i.e. NSEG register stages.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready = !v0 || stage 0 advances.
  - The ready path is combinational through the stage chain from out_ready.
  - With all stages full and out_ready=0, in_ready=0.
- Stall: while out_valid=1 and out_ready=0, s, co and os are held stable. Stages only compress bubbles; no data changes under a stall.
- Simultaneous accept and emit with a full pipe: allowed when out_ready=1. Occupancy is unchanged.
- Reset, while rst=1 at an edge:
  - All valid bits clear, so out_valid=0.
  - s=0, co=0, os=0.
  - Any in-flight beats are discarded.
  - Input transfers in that cycle are ignored.
  - in_ready=1 from the first cycle after reset is released.
- Reset mid-stream: same result. No partial beat emerges afterwards.
- NSEG=1: a single registered full-width adder with latency 1. Same handshake.

## Structure
- Package pipe_adder_pkg:
  - Function nseg(WIDTH, SEG).
  - A compile-time check that WIDTH % SEG == 0.
  - A localparam for the state record layout per stage: valid, carry, MSB carry-in, operand/sum payload.
- Sub-module pipe_adder_stage:
  - One segment adder plus its pipeline register and valid/ready logic.
  - Parametrised by SEG, WIDTH and stage index.
  - Instantiated NSEG times in a generate loop.
- Top module: c0/bb preparation, stage chaining, output mapping.

## Test plan
- Reset/idle: assert rst for 2 cycles, then release.
  - During and after reset: out_valid=0, s=0, co=0, os=0.
  - In the first post-reset cycle: in_ready=1.
- Add, WIDTH=16, SEG=8, out_ready=1:
  - 0x7FFF+0x0001, ci=0 → s=0x8000, co=0, os=1, exactly 2 cycles after accept.
  - 0xFFFF+0x0001 → s=0x0000, co=1, os=0.
- Subtract:
  - 0x0000−0x0001 (sub=1, ci=0) → s=0xFFFF, co=0, os=0.
  - 0x8000−0x0001 → s=0x7FFF, co=1, os=1.
  - 0x0005−0x0003 with ci=1 → s=0x0001, co=1.
- Backpressure:
  - Stream 6 beats with out_ready=0 → in_ready falls after 2 accepts.
  - The output stays stable.
  - After out_ready=1, all 6 results emerge in order with no loss.
- Carry across segments under stall:
  - Input 0x00FF+0x0001, stalled one cycle between stages → s=0x0100.
- Reset mid-stream:
  - Assert rst with 2 beats in flight → no stale beat emerges afterwards.
  - The next accepted beat returns the correct result.
- Random regression across WIDTH∈{8,16,32,64} and SEG∈{4,8,16}, with a golden model and random valid/ready toggling.
